// File: rtl/frame_ser_pkg.sv
// Shared types and line levels for the frame serializer.
package frame_ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;
  localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/frame_ser_hold.sv
// One-entry holding register between the upstream handshake and the shifter.
module frame_ser_hold #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              take,
  output logic              ready,
  output logic              full,
  output logic [DATA_W-1:0] data,
  output logic              full_nx_c
);

  logic accept_c;

  // take only happens while full, accept only while empty, so they never coincide
  always_comb begin
    accept_c  = in_valid && ready;
    full_nx_c = full;
    if (accept_c) begin
      full_nx_c = 1'b1;
    end else if (take) begin
      full_nx_c = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full  <= 1'b0;
      ready <= 1'b1;
      data  <= '0;
    end else begin
      full  <= full_nx_c;
      ready <= !full_nx_c;
      if (accept_c) begin
        data <= in_data;
      end
    end
  end

endmodule

// File: rtl/frame_serializer.sv
// Serializes held payloads as start bit, LSB-first payload, stop bit on a registered line.
module frame_serializer
  import frame_ser_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_d;
  logic               busy_d;
  logic               take_c;
  logic               hold_full;
  logic               hold_full_nx;
  logic [DATA_W-1:0]  hold_data;

  frame_ser_hold #(.DATA_W(DATA_W)) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .take      (take_c),
    .ready     (in_ready),
    .full      (hold_full),
    .data      (hold_data),
    .full_nx_c (hold_full_nx)
  );

  // Next-state and line-level decode; out_d is the level for the state being entered
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    out_d   = IDLE_LEVEL;
    take_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hold_full) begin
          shift_d = hold_data;
          take_c  = 1'b1;
          state_d = START;
          out_d   = START_BIT;
        end
      end
      START: begin
        state_d = DATA;
        out_d   = shift_q[0];
        cnt_d   = '0;
      end
      DATA: begin
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = STOP;
          out_d   = STOP_BIT;
        end else begin
          shift_d = shift_q >> 1;
          out_d   = shift_d[0];
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        // a held byte chains straight into the next start bit
        if (hold_full) begin
          shift_d = hold_data;
          take_c  = 1'b1;
          state_d = START;
          out_d   = START_BIT;
        end else begin
          state_d = IDLE;
          out_d   = IDLE_LEVEL;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE) || hold_full_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      out     <= IDLE_LEVEL;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      out     <= out_d;
      busy    <= busy_d;
    end
  end

endmodule
